// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: 32-bit ADD/SUB/CMP/NEG issued as two chained passes (low, then high) on a 16-bit ALU.
// Optional macro ALU_SEQ_BACK2BACK_EN: accept a new request on the same edge the response is taken.
module alu_wide_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_c,
    input  logic        alu_cout,
    input  logic [1:0]  alu_compare,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_ovf,
    output logic [1:0]  rsp_compare
);
    localparam int WORD_SIZE = 16;
    localparam int DATA_W    = 2 * WORD_SIZE;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ID  = 4'b1111;

    localparam logic [1:0] REQ_ADD = 2'b00;
    localparam logic [1:0] REQ_SUB = 2'b01;
    localparam logic [1:0] REQ_CMP = 2'b10;
    localparam logic [1:0] REQ_NEG = 2'b11;

    localparam logic [1:0] ALU_SAME = 2'b00;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_LT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic [WORD_SIZE-1:0]  res_lo_q;
    logic                  chain_q;
    logic [DATA_W-1:0]     rsp_result_q;
    logic                  rsp_carry_q, rsp_ovf_q;
    logic [1:0]            rsp_compare_q;
    logic                  accept;
    logic [DATA_W-1:0]     res_full;
    logic                  ovf_w;

    // The ALU compare output is not needed; the 32-bit compare is derived from the result.
    logic unused_alu_compare;
    assign unused_alu_compare = ^alu_compare;

    function automatic logic ovf_f(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] res);
        logic v;
        case (op)
            REQ_ADD: v = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
            REQ_NEG: v = (a == {1'b1, {(DATA_W-1){1'b0}}});
            default: v = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
        endcase
        return v;
    endfunction

    function automatic logic [1:0] compare_f(input logic [1:0] op, input logic [DATA_W-1:0] res,
                                             input logic ovf);
        logic [1:0] c;
        c = ALU_SAME;
        if ((op == REQ_SUB || op == REQ_CMP) && res != '0)
            c = (res[DATA_W-1] ^ ovf) ? CMP_LT : CMP_GT;
        return c;
    endfunction

`ifdef ALU_SEQ_BACK2BACK_EN
    assign req_ready = !reset && ((state_q == S_IDLE) || (state_q == S_DONE && rsp_ready));
`else
    assign req_ready = !reset && (state_q == S_IDLE);
`endif
    assign accept    = req_ready && req_valid;
    assign rsp_valid = (state_q == S_DONE);
    assign res_full  = {alu_c, res_lo_q};
    assign ovf_w     = ovf_f(op_q, a_q, b_q, res_full);

    always_comb begin
        state_d = state_q;
        alu_op  = OP_ID;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = S_LO;
            S_LO: begin
                alu_op  = (op_q == REQ_ADD) ? OP_ADD : OP_SUB;
                alu_a   = (op_q == REQ_NEG) ? '0 : a_q[WORD_SIZE-1:0];
                alu_b   = (op_q == REQ_NEG) ? a_q[WORD_SIZE-1:0] : b_q[WORD_SIZE-1:0];
                state_d = S_HI;
            end
            S_HI: begin
                alu_op  = (op_q == REQ_ADD) ? OP_ADD : OP_SUB;
                alu_a   = (op_q == REQ_NEG) ? '0 : a_q[DATA_W-1:WORD_SIZE];
                alu_b   = (op_q == REQ_NEG) ? a_q[DATA_W-1:WORD_SIZE] : b_q[DATA_W-1:WORD_SIZE];
                alu_cin = chain_q;
                state_d = S_DONE;
            end
            S_DONE: if (rsp_ready) state_d = accept ? S_LO : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Operand latch and low-pass capture; contents are meaningless outside a transaction.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
        end
        if (state_q == S_LO) begin
            res_lo_q <= alu_c;
            chain_q  <= alu_cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_result_q  <= '0;
            rsp_carry_q   <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_compare_q <= ALU_SAME;
        end else if (state_q == S_HI) begin
            rsp_result_q  <= res_full;
            rsp_carry_q   <= alu_cout;
            rsp_ovf_q     <= ovf_w;
            rsp_compare_q <= compare_f(op_q, res_full, ovf_w);
        end
    end

    assign rsp_result  = rsp_result_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_compare = rsp_compare_q;
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Scoreboard bench for alu_wide_sequencer with a behavioural 16-bit ALU and a 32-bit reference model.
// Honours ALU_SEQ_BACK2BACK_EN for the expected back-to-back spacing.
module tb_alu_wide_sequencer;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ID  = 4'b1111;
`ifdef ALU_SEQ_BACK2BACK_EN
    localparam int B2B_GAP = 3;
`else
    localparam int B2B_GAP = 4;
`endif

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic [1:0]  cmp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [15:0] alu_a, alu_b, alu_c;
    logic        alu_cin, alu_cout;
    logic [3:0]  alu_op;
    logic [1:0]  alu_compare;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_ovf;
    logic [1:0]  rsp_compare;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   prev_rsp_cyc = 0;
    int   last_gap = 0;
    exp_t exp_q[$];

    alu_wide_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_c(alu_c), .alu_cout(alu_cout), .alu_compare(alu_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_compare(rsp_compare)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 16-bit ALU; cout is the borrow for subtraction.
    logic [16:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_op)
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
            OP_ID:   alu_wide = {1'b0, alu_a};
            default: alu_wide = '0;
        endcase
    end
    assign alu_c       = alu_wide[15:0];
    assign alu_cout    = alu_wide[16];
    assign alu_compare = 2'b00;

    // 32-bit reference: plain integer arithmetic and a signed comparison.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [32:0] full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.cmp = 2'b00;
        case (op)
            2'b00: begin
                full  = {1'b0, a} + {1'b0, b};
                e.res = full[31:0];
                e.c   = full[32];
                s     = sa + sb;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2'b11: begin
                e.res = 32'd0 - a;
                e.c   = (a != 32'd0);
                e.v   = (a == 32'h8000_0000);
            end
            default: begin
                e.res = a - b;
                e.c   = (a < b);
                s     = sa - sb;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.cmp = (sa == sb) ? 2'b00 : ((sa > sb) ? 2'b10 : 2'b11);
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        bit got;
        got = 0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back(model(op, a, b));
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_a = $urandom;
        req_b = $urandom;
    endtask

    // Returns #1 after a rising edge.
    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            4: return {16'h0000, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap_res;
        logic [3:0]  snap_flags;
        bit          seen;

        fork
            forever begin
                @(negedge clk);
                if (!reset && rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        last_gap = cyc - prev_rsp_cyc;
                        prev_rsp_cyc = cyc;
                        e = exp_q.pop_front();
                        chk("rsp_result", 64'(rsp_result), 64'(e.res));
                        chk("rsp_carry", 64'(rsp_carry), 64'(e.c));
                        chk("rsp_ovf", 64'(rsp_ovf), 64'(e.v));
                        chk("rsp_compare", 64'(rsp_compare), 64'(e.cmp));
                    end
                end
            end
        join_none

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_alu_port", 64'({alu_op, alu_a, alu_b, alu_cin}), 64'({OP_ID, 16'd0, 16'd0, 1'b0}));
        chk("rst_rsp_data", 64'({rsp_result, rsp_carry, rsp_ovf, rsp_compare}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Carry chaining and latency
        send(2'b00, 32'h0000_FFFF, 32'h0000_0001, 1);
        @(negedge clk);
        chk("lo_cout", 64'(alu_cout), 64'd1);
        chk("lo_cin", 64'(alu_cin), 64'd0);
        chk("lo_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("hi_cin", 64'(alu_cin), 64'd1);
        chk("hi_no_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", 64'(rsp_valid), 64'd1);
        drain();

        // Directed vectors
        send(2'b01, 32'h0001_0000, 32'h0000_0001, 1);
        send(2'b10, 32'h8000_0000, 32'h0000_0001, 1);
        send(2'b10, 32'h1234_5678, 32'h1234_5678, 1);
        send(2'b11, 32'h0000_0001, 32'h5555_5555, 1);
        send(2'b11, 32'h8000_0000, 32'h0000_0000, 1);
        send(2'b01, 32'h0000_0001, 32'h0000_0002, 1);
        drain();

        // Backpressure
        rsp_ready = 1'b0;
        send(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1);
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1; break; end
        end
        chk("bp_valid_seen", 64'(seen), 64'd1);
        snap_res = rsp_result;
        snap_flags = {rsp_carry, rsp_ovf, rsp_compare};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_hold", 64'({rsp_valid, req_ready, rsp_result, rsp_carry, rsp_ovf, rsp_compare}),
                64'({1'b1, 1'b0, snap_res, snap_flags}));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Reset during the high pass
        send(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({rsp_valid, req_ready}), 64'd0);
        chk("midrst_alu_port", 64'({alu_op, alu_a, alu_b, alu_cin}), 64'({OP_ID, 16'd0, 16'd0, 1'b0}));
        chk("midrst_rsp_data", 64'({rsp_result, rsp_carry, rsp_ovf, rsp_compare}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back
        send(2'b00, 32'h0000_0001, 32'h0000_0001, 1);
        send(2'b00, 32'h0000_0002, 32'h0000_0002, 1);
        drain();
        chk("b2b_gap", 64'(last_gap), 64'(B2B_GAP));

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            send(2'($urandom), pick(), pick(), 1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
